validready2noc_injection_arbiter: RTL and testbench

VALIDREADY2NOC_INJECTION_ARBITER -- requirements
Module: validready2noc_injection_arbiter

---
 rtl/validready2noc_injection_arbiter.sv | 130 +++++++++++++
 tb/tb_validready2noc_injection_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/validready2noc_injection_arbiter.sv
// Round-robin, packet-locked arbiter that funnels NUM_PORTS valid/ready flit
// streams into a single one-entry injection register feeding a NoC router.
module validready2noc_injection_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int PTR_W      = $clog2(NUM_PORTS)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS-1:0]            valid_i,
   output logic [NUM_PORTS-1:0]            ready_o,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
   input  logic [NUM_PORTS-1:0]            last_i,
   output logic [DATA_WIDTH-1:0]           data_o,
   output logic                            valid_o,
   input  logic                            avail_i,
   output logic [PTR_W-1:0]                grant_o,
   output logic                            busy_o
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [PTR_W:0]   NUM_PORTS_EXT = (PTR_W+1)'(NUM_PORTS);
   localparam logic [PTR_W-1:0] LAST_PORT     = PTR_W'(NUM_PORTS - 1);

   state_t                state_q;
   state_t                state_d;
   logic [PTR_W-1:0]      rr_ptr_q;
   logic [PTR_W-1:0]      grant_q;
   logic [PTR_W-1:0]      winner;
   logic                  any_req;
   logic                  out_full_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] granted_flit;
   logic                  slot_free;
   logic                  in_xfer;
   logic                  out_xfer;
   logic                  tail_accepted;

   // Search upward from rr_ptr with wrap-around; the first requester wins.
   always_comb begin
      logic [PTR_W:0] cand;
      winner  = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
         if (cand >= NUM_PORTS_EXT) begin
            cand = cand - NUM_PORTS_EXT;
         end
         if (!any_req && valid_i[cand[PTR_W-1:0]]) begin
            any_req = 1'b1;
            winner  = cand[PTR_W-1:0];
         end
      end
   end

   assign granted_flit  = data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign slot_free     = !out_full_q || avail_i;
   assign in_xfer       = (state_q == LOCKED) && valid_i[grant_q] && slot_free;
   assign out_xfer      = out_full_q && avail_i;
   assign tail_accepted = in_xfer && last_i[grant_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_accepted) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are forced low during reset so no buffered flit escapes.
   always_comb begin
      ready_o = '0;
      busy_o  = 1'b0;
      valid_o = 1'b0;
      if (!rst_i) begin
         valid_o = out_xfer;
         if (state_q == LOCKED) begin
            busy_o           = 1'b1;
            ready_o[grant_q] = slot_free;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else if ((state_q == IDLE) && any_req) begin
         grant_q <= winner;
      end else if (tail_accepted) begin
         rr_ptr_q <= (grant_q == LAST_PORT) ? '0 : grant_q + PTR_W'(1);
      end
   end

   // A simultaneous accept and emit reloads the register and keeps it full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_full_q <= 1'b0;
         data_q     <= '0;
      end else if (in_xfer) begin
         out_full_q <= 1'b1;
         data_q     <= granted_flit;
      end else if (out_xfer) begin
         out_full_q <= 1'b0;
      end
   end

   assign grant_o = grant_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_validready2noc_injection_arbiter.sv
// Directed and randomized checks of the injection arbiter against a
// packet-level reference model kept in the bench.
module tb_validready2noc_injection_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int PW = 2;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [NP-1:0]    valid_i;
   logic [NP-1:0]    ready_o;
   logic [NP*DW-1:0] data_i;
   logic [NP-1:0]    last_i;
   logic [DW-1:0]    data_o;
   logic             valid_o;
   logic             avail_i;
   logic [PW-1:0]    grant_o;
   logic             busy_o;

   validready2noc_injection_arbiter #(
      .NUM_PORTS (NP),
      .DATA_WIDTH(DW)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .data_i (data_i),
      .last_i (last_i),
      .data_o (data_o),
      .valid_o(valid_o),
      .avail_i(avail_i),
      .grant_o(grant_o),
      .busy_o (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Per-port sources: each entry is {last, data}.
   logic [DW:0]   pend [NP][$];
   bit            hold [NP];

   // Reference model: which port owns the link, where the next search starts,
   // and the single flit waiting for the router.
   bit            m_known;
   bit            m_locked;
   int            m_owner;
   int            m_start;
   bit            m_held;
   logic [DW-1:0] m_data;

   logic [DW-1:0] seen [$];
   logic [DW-1:0] expq [$];
   int            tests_run;
   int            tests_failed;
   int            seq;

   task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkOutput();
      logic [NP-1:0] exp_ready;
      bit            exp_valid;
      bit            exp_busy;
      exp_valid = !rst_i && m_held && avail_i;
      exp_busy  = !rst_i && m_locked;
      exp_ready = '0;
      if (exp_busy) exp_ready[m_owner] = !m_held || avail_i;
      checkValue("valid_o", 64'(valid_o), 64'(exp_valid));
      checkValue("ready_o", 64'(ready_o), 64'(exp_ready));
      checkValue("busy_o", 64'(busy_o), 64'(exp_busy));
      checkValue("data_o", data_o, m_data);
      if (exp_busy) checkValue("grant_o", 64'(grant_o), 64'(m_owner));
      if (valid_o === 1'b1) seen.push_back(data_o);
   endtask

   task automatic updateModel();
      bit          was_locked;
      bit          emit;
      bit          acc;
      bit          found;
      logic [DW:0] head;
      int          p;
      if (rst_i) begin
         m_locked = 0;
         m_owner  = 0;
         m_start  = 0;
         m_held   = 0;
         m_data   = '0;
         m_known  = 1;
         for (int i = 0; i < NP; i++) pend[i].delete();
         return;
      end
      was_locked = m_locked;
      emit = m_held && avail_i;
      acc  = m_locked && valid_i[m_owner] && (!m_held || avail_i);
      if (acc) begin
         head = pend[m_owner].pop_front();
         m_data = head[DW-1:0];
         m_held = 1;
         if (head[DW]) begin
            m_locked = 0;
            m_start  = (m_owner + 1) % NP;
         end
      end else if (emit) begin
         m_held = 0;
      end
      if (!was_locked) begin
         found = 0;
         for (int k = 0; k < NP; k++) begin
            p = (m_start + k) % NP;
            if (!found && valid_i[p]) begin
               found   = 1;
               m_owner = p;
            end
         end
         m_locked = found;
      end
   endtask

   task automatic applyStimulus(input bit avail, input bit rst);
      logic [DW:0] head;
      @(negedge clk_i);
      rst_i   = rst;
      avail_i = avail;
      for (int p = 0; p < NP; p++) begin
         if (pend[p].size() > 0 && !hold[p]) begin
            head = pend[p][0];
            valid_i[p]           = 1'b1;
            data_i[p*DW +: DW]   = head[DW-1:0];
            last_i[p]            = head[DW];
         end else begin
            valid_i[p]           = 1'b0;
            data_i[p*DW +: DW]   = {$urandom, $urandom};
            last_i[p]            = 1'($urandom_range(0, 1));
         end
      end
      #1;
      if (m_known) checkOutput();
      @(posedge clk_i);
      updateModel();
   endtask

   task automatic pushPacket(input int port, input logic [DW-1:0] base, input int len);
      for (int i = 0; i < len; i++) pend[port].push_back({(i == len - 1), base + DW'(i)});
   endtask

   function automatic bit modelBusy();
      bit b;
      b = m_locked || m_held;
      for (int p = 0; p < NP; p++) if (pend[p].size() > 0) b = 1;
      return b;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      for (int p = 0; p < NP; p++) hold[p] = 0;
      while (modelBusy() && n < budget) begin
         applyStimulus(1'b1, 1'b0);
         n++;
      end
      checkValue({tag, " drained in budget"}, 64'(n < budget), 64'd1);
   endtask

   task automatic checkSeen(input string tag);
      checkValue({tag, " flit count"}, 64'(seen.size()), 64'(expq.size()));
      for (int i = 0; i < seen.size() && i < expq.size(); i++)
         checkValue({tag, " flit"}, seen[i], expq[i]);
      seen.delete();
      expq.delete();
   endtask

   task automatic resetDut();
      applyStimulus(1'b1, 1'b1);
      seen.delete();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      seq          = 0;
      m_known      = 0;
      rst_i        = 1'b1;
      avail_i      = 1'b0;
      valid_i      = '0;
      last_i       = '0;
      data_i       = '0;
      for (int p = 0; p < NP; p++) hold[p] = 0;

      // Power-up reset; the second reset cycle is fully checked.
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkValue("reset grant_o", 64'(grant_o), 64'd0);
      checkValue("reset data_o", data_o, 64'd0);

      // Single port, three-flit packet.
      resetDut();
      pushPacket(2, 64'hA, 3);
      applyStimulus(1'b1, 1'b0);
      #1;
      checkValue("single grant_o", 64'(grant_o), 64'd2);
      checkValue("single busy_o", 64'(busy_o), 64'd1);
      drain("single", 50);
      #1;
      checkValue("single busy after", 64'(busy_o), 64'd0);
      expq = '{64'hA, 64'hB, 64'hC};
      checkSeen("single");

      // Round robin over four single-flit packets, port 0 holding two.
      resetDut();
      pushPacket(0, 64'h10, 1);
      pushPacket(0, 64'h14, 1);
      pushPacket(1, 64'h11, 1);
      pushPacket(2, 64'h12, 1);
      pushPacket(3, 64'h13, 1);
      drain("rr", 50);
      expq = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14};
      checkSeen("rr");

      // Backpressure mid-packet.
      resetDut();
      pushPacket(0, 64'h30, 6);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0);
         #1;
         checkValue("bp data hold", data_o, 64'h31);
      end
      drain("bp", 50);
      expq = '{64'h30, 64'h31, 64'h32, 64'h33, 64'h34, 64'h35};
      checkSeen("bp");

      // Port 0 requests while port 1 holds the lock.
      resetDut();
      pushPacket(1, 64'h40, 4);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      pushPacket(0, 64'h50, 1);
      drain("nointerleave", 50);
      expq = '{64'h40, 64'h41, 64'h42, 64'h43, 64'h50};
      checkSeen("nointerleave");

      // Reset after the second flit of a four-flit packet.
      resetDut();
      pushPacket(0, 64'h60, 4);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkValue("midreset valid_o", 64'(valid_o), 64'd0);
      checkValue("midreset busy_o", 64'(busy_o), 64'd0);
      checkValue("midreset ready_o", 64'(ready_o), 64'd0);
      checkValue("midreset data_o", data_o, 64'd0);
      pushPacket(3, 64'h73, 1);
      pushPacket(1, 64'h71, 1);
      applyStimulus(1'b1, 1'b0);
      #1;
      checkValue("midreset next grant", 64'(grant_o), 64'd1);
      drain("midreset", 50);
      expq = '{64'h60, 64'h71, 64'h73};
      checkSeen("midreset");

      // Randomized traffic with withdrawals, backpressure and rare resets.
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (pend[p].size() < 6 && $urandom_range(0, 9) < 3) begin
               seq++;
               pushPacket(p, {8'(p), 40'd0, 16'(seq)} << 0, int'($urandom_range(1, 4)));
            end
            hold[p] = ($urandom_range(0, 9) == 0);
         end
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
      drain("random", 400);
      seen.delete();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
